// File: rtl/johnson_seq_ctrl.sv
// Sequencer around a WIDTH-bit Johnson (twisted-ring) counter.
// It runs a counted or free-running number of rotations and supports hold and abort.
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int PH_W  = 3,
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic [CYC_W-1:0] cycles,
  output logic [WIDTH-1:0] q,
  output logic [PH_W-1:0]  phase,
  output logic             phase_tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(2*WIDTH-1);
  localparam logic [CYC_W-1:0] REM_ONE = CYC_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] jc_q, jc_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CYC_W-1:0] rem_q, rem_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic do_start, do_abort, do_adv, do_wrap, last_wrap;

  // Decoded control events for this cycle; priority is stop > hold > advance.
  always_comb begin
    do_start  = (state_q == S_IDLE) && start && !stop;
    do_abort  = (state_q != S_IDLE) && stop;
    do_adv    = (state_q == S_RUN) && !stop && !hold;
    do_wrap   = do_adv && (ph_q == PH_LAST);
    last_wrap = do_wrap && (rem_q == REM_ONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      jc_q    <= '0;
      ph_q    <= '0;
      rem_q   <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      jc_q    <= jc_d;
      ph_q    <= ph_d;
      rem_q   <= rem_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (do_start) state_d = S_RUN;
      S_RUN: begin
        if (stop)           state_d = S_IDLE;
        else if (hold)      state_d = S_HOLD;
        else if (last_wrap) state_d = S_IDLE;
      end
      S_HOLD: begin
        if (stop)       state_d = S_IDLE;
        else if (!hold) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    jc_d   = jc_q;
    ph_d   = ph_q;
    rem_d  = rem_q;
    tick_d = do_adv;
    done_d = last_wrap;
    busy_d = (state_d != S_IDLE);
    if (do_start || do_abort) begin
      jc_d = '0;
      ph_d = '0;
    end
    if (do_start) rem_d = cycles;
    if (do_abort) rem_d = '0;
    if (do_adv) begin
      jc_d = {jc_q[WIDTH-2:0], ~jc_q[WIDTH-1]};
      ph_d = do_wrap ? '0 : ph_q + 1'b1;
      // A zero count means free-run, so the counter never moves off zero.
      if (do_wrap && (rem_q > REM_ONE)) rem_d = rem_q - 1'b1;
      if (last_wrap) rem_d = '0;
    end
  end

  assign q          = jc_q;
  assign phase      = ph_q;
  assign phase_tick = tick_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl (WIDTH=4).
// Stimulus queues the expected outputs; a monitor compares them after each edge.
module tb_johnson_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, hold = 1'b0;
  logic [7:0] cycles = '0;
  logic [3:0] q;
  logic [2:0] phase;
  logic       phase_tick, busy, done;

  johnson_seq_ctrl #(.WIDTH(4), .PH_W(3), .CYC_W(8)) dut (
    .clk(clk), .reset(rst_n), .start(start), .stop(stop), .hold(hold),
    .cycles(cycles), .q(q), .phase(phase), .phase_tick(phase_tick),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         tid;
    logic [3:0] q;
    logic [2:0] ph;
    logic       tk, bz, dn;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [3:0] jseq [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  // Monitor: one expected entry per sampled cycle.
  always @(posedge clk) begin
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || q !== e.q || phase !== e.ph || phase_tick !== e.tk ||
          busy !== e.bz || done !== e.dn) begin
        errors++;
        $display("FAIL t%0d cyc=%0d got q=%h ph=%0d tick=%b busy=%b done=%b exp q=%h ph=%0d tick=%b busy=%b done=%b",
                 e.tid, cyc, q, phase, phase_tick, busy, done, e.q, e.ph, e.tk, e.bz, e.dn);
      end
    end
  end

  task automatic step(input int tid, input logic rs, st, sp, hd, input logic [7:0] cy,
                      input logic [3:0] eq, input logic [2:0] ep,
                      input logic et, eb, ed);
    exp_t e;
    @(negedge clk);
    rst_n = rs; start = st; stop = sp; hold = hd; cycles = cy;
    e.cyc = cyc + 1; e.tid = tid; e.q = eq; e.ph = ep; e.tk = et; e.bz = eb; e.dn = ed;
    sb.push_back(e);
  endtask

  // Advance k of a run of total rotations*8 edges (total=0: free-run).
  task automatic adv(input int tid, input int k, input int total, input logic st);
    step(tid, 1, st, 0, 0, 8'd0, jseq[k%8], 3'(k%8), 1'b1,
         (total == 0) || (k < total), (total != 0) && (k == total));
  endtask

  task automatic idle(input int tid, input logic st, input logic sp);
    step(tid, 1, st, sp, 0, 8'd0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // t0: reset state
    step(0, 0, 0, 0, 0, 8'd0, 4'h0, 3'd0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'd0, 4'h0, 3'd0, 0, 0, 0);
    idle(0, 0, 1);
    // t1: cycles=1, start during RUN (k=3) and on the wrap edge (k=8) ignored
    step(1, 1, 1, 0, 0, 8'd1, 4'h0, 3'd0, 0, 1, 0);
    for (int k = 1; k <= 8; k++) adv(1, k, 8, (k == 3) || (k == 8));
    idle(1, 0, 0);
    // t2: cycles=3, single done after 24 ticks
    step(2, 1, 1, 0, 0, 8'd3, 4'h0, 3'd0, 0, 1, 0);
    for (int k = 1; k <= 24; k++) adv(2, k, 24, 0);
    idle(2, 0, 0);
    // t3: hold 5 cycles at q=7, then resume with no advance on the exit edge
    step(3, 1, 1, 0, 0, 8'd1, 4'h0, 3'd0, 0, 1, 0);
    for (int k = 1; k <= 3; k++) adv(3, k, 8, 0);
    for (int i = 0; i < 5; i++) step(3, 1, 0, 0, 1, 8'd0, 4'h7, 3'd3, 0, 1, 0);
    step(3, 1, 0, 0, 0, 8'd0, 4'h7, 3'd3, 0, 1, 0);
    for (int k = 4; k <= 8; k++) adv(3, k, 8, 0);
    idle(3, 0, 0);
    // t4: free-run 40 edges, then stop with hold
    step(4, 1, 1, 0, 0, 8'd0, 4'h0, 3'd0, 0, 1, 0);
    for (int k = 1; k <= 40; k++) adv(4, k, 0, 0);
    step(4, 1, 0, 1, 1, 8'd0, 4'h0, 3'd0, 0, 0, 0);
    idle(4, 0, 0);
    // t5: start and stop together in IDLE
    idle(5, 1, 1);
    idle(5, 0, 0);
    // t6: reset mid-run at q=E, then reset with start held high
    step(6, 1, 1, 0, 0, 8'd2, 4'h0, 3'd0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) adv(6, k, 16, 0);
    step(6, 0, 0, 0, 0, 8'd0, 4'h0, 3'd0, 0, 0, 0);
    step(6, 0, 1, 0, 0, 8'd2, 4'h0, 3'd0, 0, 0, 0);
    idle(6, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries never compared, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
- Sequencer/controller wrapped around a WIDTH-bit twisted-ring (Johnson) counter.
- Runs a programmable number of full rotations (0,1,3,7,F,E,C,8,0 for WIDTH=4), or free-runs.
- Supports hold (freeze) and abort, and reports phase index, per-step tick, busy and done.
- Drives phase-gated logic downstream; the Johnson register lives inside this block.

Parameters:
- WIDTH, 4, Johnson register width; sequence length is 2*WIDTH states.
- PH_W, 3, width of the binary phase index; requires 2**PH_W >= 2*WIDTH.
- CYC_W, 8, width of the rotation-count input and its internal down-counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- start  input  1  begin a run; sampled only in IDLE.
- stop  input  1  abort the run; return to IDLE.
- hold  input  1  freeze the counter while RUN/HOLD.
- cycles  input  CYC_W  rotations to execute; 0 = free-run until stop. Latched on accepted start.
- q  output  WIDTH  Johnson counter value.
- phase  output  PH_W  binary step index 0..2*WIDTH-1, tracks q.
- phase_tick  output  1  high for the one cycle following each advance of q.
- busy  output  1  high in RUN or HOLD.
- done  output  1  one-cycle pulse when a counted run completes.

Behaviour:
- Reset (reset==0 at an edge) forces: state=IDLE, q=0, phase=0, remaining=0, phase_tick=0, busy=0, done=0. Reset overrides every other input, including mid-run.
- All outputs are registered; no combinational input-to-output paths.
- States and transitions:
  - IDLE: start=1 and stop=0 → RUN, q<=0, phase<=0, remaining<=cycles, busy<=1. Otherwise stay; q holds 0. stop in IDLE has no effect.
  - RUN:
    - stop=1 → IDLE, q<=0, phase<=0, busy<=0, no done.
    - Else hold=1 → HOLD, q frozen.
    - Else advance: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}; phase <= phase+1, wrapping 2*WIDTH-1→0; phase_tick<=1.
  - HOLD:
    - stop=1 → IDLE as above.
    - Else hold=0 → RUN; no advance on the exiting edge.
    - Else stay; q and phase frozen.
- Priority: reset > stop > hold > advance. start is ignored while busy, including the wrap cycle.
- Wrap and count:
  - A wrap is an advance with phase == 2*WIDTH-1, i.e. q goes from 1<<(WIDTH-1) to 0.
  - If remaining==1 at a wrap: state→IDLE, busy<=0, done<=1 for exactly one cycle, q=0.
  - If remaining>1 at a wrap: remaining decrements.
  - If remaining==0 (free-run): never decrements, never completes.
- Latency: start sampled at edge E0 → q=0/busy=1 after E0; first advance at E1. For cycles=N, done is high after edge E0+2*WIDTH*N for one cycle; with WIDTH=4, N=1 that is E8.
- phase_tick is 0 in IDLE, in HOLD, and on the HOLD→RUN edge.
- Only the 2*WIDTH legal Johnson codes are ever produced; q always equals the decode of phase.

Test Plan:
- Reset then start with cycles=1 (WIDTH=4) → q after E1..E8 = 1,3,7,F,E,C,8,0; phase 1..7,0; done=1 only after E8; busy falls with done.
- cycles=3 → exactly 24 phase_tick pulses, single done after E24, no intermediate done.
- hold asserted for 5 cycles while q=7 → q stays 7, phase stays 3, phase_tick=0, busy=1; resumes to F one edge after hold deasserts; done delayed by 6 cycles total vs unheld run.
- cycles=0 free-run for 40 edges, then stop together with hold → next cycle state IDLE, q=0, busy=0, done never asserted.
- start during RUN and on the wrap edge → ignored; start and stop together in IDLE → stays IDLE.
- reset driven low mid-run at q=E → after that edge q=0, phase=0, busy=0, done=0; reset low while start=1 → remains IDLE.
